// File: rtl/axis_to_serial.sv
// axis_to_serial
//   Accepts words on an AXI-Stream slave port and shifts them out MSB first
//   as an SPI mode-0 slave. The serial clock and chip select come from an
//   external master and are asynchronous to aclk. They are oversampled
//   through a synchronizer, so sck high and low times must each be at least
//   4 aclk periods.
//
//   Optional feature: define AXIS_TO_SERIAL_FIFO_EN to replace the single
//   holding register with a 4-entry FIFO. Without the macro, one holding
//   register sits in front of the shift register.
//
// Parameters
//   DATA_WIDTH   word width shifted per transfer
//   SYNC_STAGES  synchronizer depth for serial_sck / serial_cs
//
// Ports
//   aclk           system clock, rising edge
//   resetn         synchronous active-low reset
//   s_axis_tvalid  word valid
//   s_axis_tready  word accepted when high together with tvalid
//   s_axis_tdata   word to transmit
//   serial_sck     external serial clock (async)
//   serial_cs      chip select, active low (async)
//   serial_miso    serial data out, MSB first
//   serial_rts     high while a complete word is loaded or shifting
//
// FSM states
//   state      | meaning
//   ST_IDLE    | shift register empty; miso driven 0
//   ST_LOADED  | word in shift register, waiting for cs to fall
//   ST_SHIFT   | cs low, word being clocked out

module axis_to_serial #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  aclk,
   input  logic                  resetn,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  serial_sck,
   input  logic                  serial_cs,
   output logic                  serial_miso,
   output logic                  serial_rts
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOADED = 2'd1;
   localparam logic [1:0] ST_SHIFT  = 2'd2;

   localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   // synchronizers and edge detection
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   sck_prev_q, cs_prev_q;
   logic                   sck_s, cs_s;
   logic                   sck_rise, sck_fall, cs_rise, cs_fall;

   always_comb begin
      sck_sync_d = SYNC_STAGES'({sck_sync_q, serial_sck});
      cs_sync_d  = SYNC_STAGES'({cs_sync_q, serial_cs});
      sck_s      = sck_sync_q[SYNC_STAGES-1];
      cs_s       = cs_sync_q[SYNC_STAGES-1];
      sck_rise   = sck_s & ~sck_prev_q;
      sck_fall   = ~sck_s & sck_prev_q;
      cs_rise    = cs_s & ~cs_prev_q;
      cs_fall    = ~cs_s & cs_prev_q;
   end

   // word buffer in front of the shift register
   logic                  buf_valid;
   logic                  buf_ready;
   logic [DATA_WIDTH-1:0] buf_data;
   logic                  push;
   logic                  take;
   logic                  ready_en_q;

   // ready is held low during reset and for the edge that releases it
   assign s_axis_tready = ready_en_q & buf_ready;
   assign push          = s_axis_tvalid & s_axis_tready;

`ifdef AXIS_TO_SERIAL_FIFO_EN
   logic [DATA_WIDTH-1:0] fifo_mem_q [4];
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   logic [2:0]            count_q, count_d;

   always_comb begin
      buf_valid = (count_q != 3'd0);
      buf_ready = (count_q != 3'd4);
      buf_data  = fifo_mem_q[rd_ptr_q];
      wr_ptr_d  = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
      rd_ptr_d  = take ? rd_ptr_q + 2'd1 : rd_ptr_q;
      case ({push, take})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   // storage needs no reset; the pointers define what is valid
   always_ff @(posedge aclk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= s_axis_tdata;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
`else
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_full_q, hold_full_d;

   always_comb begin
      buf_valid   = hold_full_q;
      buf_ready   = ~hold_full_q;
      buf_data    = hold_data_q;
      hold_data_d = push ? s_axis_tdata : hold_data_q;
      hold_full_d = (hold_full_q & ~take) | push;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
      end else begin
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
      end
   end
`endif

   // shift engine
   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  miso_q, miso_d;
   logic                  rts_q, rts_d;

   // word_q keeps the unshifted copy so an aborted word can restart from its MSB
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      take      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // never load while cs is held low, so a half-selected master
            // cannot see a word start mid-frame
            if (buf_valid && cs_s) begin
               take      = 1'b1;
               word_d    = buf_data;
               shift_d   = buf_data;
               bit_cnt_d = '0;
               state_d   = ST_LOADED;
            end
         end
         ST_LOADED: begin
            if (cs_fall) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               shift_d   = word_q;
               bit_cnt_d = '0;
               state_d   = ST_LOADED;
            end else if (sck_rise) begin
               if (bit_cnt_q == CNT_LAST) begin
                  bit_cnt_d = '0;
                  if (buf_valid) begin
                     take    = 1'b1;
                     word_d  = buf_data;
                     shift_d = buf_data;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (sck_fall && bit_cnt_q != '0) begin
               // a fall with no rise yet in this word (entry, or right after
               // a back-to-back reload) must not skip the MSB
               shift_d = shift_q << 1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rts_d  = (state_d != ST_IDLE);
      miso_d = (state_d == ST_SHIFT) ? shift_d[DATA_WIDTH-1] : 1'b0;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         sck_sync_q <= '1;
         cs_sync_q  <= '1;
         sck_prev_q <= 1'b1;
         cs_prev_q  <= 1'b1;
         ready_en_q <= 1'b0;
         state_q    <= ST_IDLE;
         word_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         miso_q     <= 1'b0;
         rts_q      <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         cs_sync_q  <= cs_sync_d;
         sck_prev_q <= sck_s;
         cs_prev_q  <= cs_s;
         ready_en_q <= 1'b1;
         state_q    <= state_d;
         word_q     <= word_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         miso_q     <= miso_d;
         rts_q      <= rts_d;
      end
   end

   assign serial_miso = miso_q;
   assign serial_rts  = rts_q;

endmodule
